// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared types and parameter helpers for the pipelined adder
package adder_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } add_op_e;

  function automatic int slice_width(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

  function automatic bit params_ok(input int width, input int stages);
    return (width >= 1) && (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice_stage.sv
// rtl/adder_slice_stage.sv - one carry slice plus its pipeline register
module adder_slice_stage #(
  parameter int WIDTH = 32,
  parameter int SL    = 8,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  input  logic             in_carry,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_sum,
  output logic             out_valid,
  output logic             out_carry,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_sum
);

  logic [SL-1:0]    slice_sum;
  logic             slice_carry;
  logic             valid_d, valid_q;
  logic             carry_d, carry_q;
  logic [WIDTH-1:0] a_d, a_q;
  logic [WIDTH-1:0] b_d, b_q;
  logic [WIDTH-1:0] sum_d, sum_q;

  always_comb begin
    {slice_carry, slice_sum} = {1'b0, in_a[IDX*SL +: SL]}
                             + {1'b0, in_b[IDX*SL +: SL]}
                             + {{SL{1'b0}}, in_carry};
    valid_d = valid_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    if (en) begin
      valid_d = in_valid;
      carry_d = slice_carry;
      // full operands travel along so the last stage can derive signed overflow
      a_d     = in_a;
      b_d     = in_b;
      sum_d   = in_sum;
      sum_d[IDX*SL +: SL] = slice_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
    end
  end

  assign out_valid = valid_q;
  assign out_carry = carry_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_sum   = sum_q;

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - sliced, pipelined add/subtract with valid/ready handshake
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SL = slice_width(WIDTH, STAGES);

  if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
    $error("pipelined_adder: WIDTH must be a nonzero multiple of STAGES");
  end

  add_op_e          op;
  logic             advance;
  logic [STAGES:0]  v_s;
  logic [STAGES:0]  c_s;
  logic [WIDTH-1:0] a_s [STAGES+1];
  logic [WIDTH-1:0] b_s [STAGES+1];
  logic [WIDTH-1:0] s_s [STAGES+1];

  assign op      = add_op_e'(sub);
  // the whole pipe moves or freezes together; bubbles are kept
  assign advance = !out_valid || out_ready;

  assign v_s[0] = in_valid;
  assign c_s[0] = cin ^ (op == OP_SUB);
  assign a_s[0] = a;
  assign b_s[0] = (op == OP_SUB) ? ~b : b;
  assign s_s[0] = '0;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_slice_stage #(
      .WIDTH (WIDTH),
      .SL    (SL),
      .IDX   (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (advance),
      .in_valid  (v_s[k]),
      .in_carry  (c_s[k]),
      .in_a      (a_s[k]),
      .in_b      (b_s[k]),
      .in_sum    (s_s[k]),
      .out_valid (v_s[k+1]),
      .out_carry (c_s[k+1]),
      .out_a     (a_s[k+1]),
      .out_b     (b_s[k+1]),
      .out_sum   (s_s[k+1])
    );
  end

  assign in_ready  = advance;
  assign out_valid = v_s[STAGES];
  assign cout      = c_s[STAGES];
  assign sum       = s_s[STAGES];
  assign ovf       = (a_s[STAGES][WIDTH-1] == b_s[STAGES][WIDTH-1])
                  && (s_s[STAGES][WIDTH-1] != a_s[STAGES][WIDTH-1]);

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
Parametrised, pipelined WIDTH-bit add/subtract unit with carry-in, carry-out and signed-overflow outputs. It generalises the team's 8-bit combinational adder.
The carry chain is split into STAGES equal slices, one registered slice per cycle, so wide adds close timing at full clock rate.
Valid/ready handshakes on input and output let it sit inside streaming datapaths with backpressure.

Parameters:
WIDTH, 32, operand/result width in bits; must be ≥1.
STAGES, 4, pipeline depth = number of carry slices; WIDTH % STAGES must be 0; STAGES ≥ 1.

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  synchronous, active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  unit can accept a beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: a+b+cin; 1: a-b-cin
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
sum  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  carry-out; in sub mode 1 = no borrow
ovf  output  1  two's-complement signed overflow

Behaviour:
- Arithmetic: effective B = sub ? ~b : b; effective carry-in = cin ^ sub. {cout,sum} = a + effB + effcin, computed at WIDTH+1 bits.
- ovf = (a[MSB] == effB[MSB]) && (sum[MSB] != a[MSB]).
- Slicing: SL = WIDTH/STAGES. Stage k (0..STAGES-1) adds bits [k*SL +: SL] using the registered carry from stage k-1 (stage 0 uses effcin).
  - Upper operand slices are carried forward (skewed) unmodified.
  - Completed lower sum slices are carried forward to the output.
  - A valid bit travels with each stage.
- Transfer: a beat is accepted when in_valid && in_ready. A result is consumed when out_valid && out_ready.
- Latency: exactly STAGES cycles from the acceptance edge to out_valid high, when not stalled. Throughput: 1 beat/cycle.
- Stall: advance = !out_valid || out_ready; in_ready = advance.
  - Whole pipeline freezes when !advance. Bubbles are not compressed.
  - in_ready depends combinationally on out_ready only.
- Held outputs: while out_valid && !out_ready, sum/cout/ovf are stable.
- Ordering: results leave in acceptance order, with no drop and no duplication.
- Inputs when not accepted (in_valid=0 or in_ready=0) are ignored. Data registers may load don't-care values under an invalid stage.
- Simultaneous accept and output consume in the same cycle is legal; both happen.
- Reset: while rst_n=0 at a clock edge:
  - all stage valid bits → 0; out_valid=0; sum=0, cout=0, ovf=0.
  - in_ready reads 1 during and after reset.
  - In-flight beats are discarded; the first result after reset comes from a beat accepted after reset deasserts.
- STAGES=1: a single registered stage, latency 1.
- Illegal parameters (WIDTH % STAGES ≠ 0) → elaboration-time error.

Decomposition:
- Shared package adder_pkg:
  - add_op_e enum (OP_ADD=0, OP_SUB=1).
  - Function slice_width(WIDTH, STAGES).
  - Elaboration check constant/function.
- One natural sub-module: adder_slice_stage (parameter SL).
  - Contents: one slice adder plus the stage register (valid, carry, partial sum, skewed operands), with an enable port.
  - Top level generates STAGES instances.

Test Plan:
1. WIDTH=8, STAGES=2: a=255, b=0, cin=0, add → sum=255, cout=0, ovf=0, out_valid exactly 2 cycles after accept. Then a=0, b=255, cin=1 → sum=0, cout=1.
2. WIDTH=8, STAGES=2, carry across slice boundary: 255+1 → sum=0, cout=1. 255+255 with cin=1 → sum=255, cout=1. 0x7F+0x01 → sum=0x80, ovf=1.
3. WIDTH=8, subtract:
   - 0-1, cin=0 → sum=0xFF, cout=0 (borrow), ovf=0.
   - 0x80-1 → sum=0x7F, ovf=1.
   - 5-3 with cin=1 → sum=1, cout=1.
4. Stream of 16 random beats with out_ready toggling pseudo-randomly → results match a reference model in order. in_ready=0 only in cycles with out_valid=1 && out_ready=0. Outputs stay stable while stalled.
5. Reset mid-flight: 2 beats in flight, rst_n=0 for one edge → next cycle out_valid=0, sum=0. No stale result ever appears. A beat accepted after reset emerges after exactly STAGES cycles.
6. Defaults (32/4): 0xFFFFFFFF+0 with cin=1 → sum=0, cout=1, latency 4. 0x80000000-1 (sub) → sum=0x7FFFFFFF, ovf=1.
